// File: rtl/ex_pkg.sv
// ex_pkg: shared EX-stage types and constants.
//   - Branch op codes (3 bits) decoded by ex_br_resolve.
//   - entry_t: one buffered EX result (sum, dest reg, PC, branch outcome, exception flag).
//   - state_e: result-stage control state, RUN = 0, TRAP = 1.
package ex_pkg;

    localparam int unsigned EX_DW = 32;
    localparam int unsigned EX_RW = 5;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BEQ     = 3'b001;
    localparam logic [2:0] BNE     = 3'b010;
    localparam logic [2:0] BLTZ    = 3'b011;
    localparam logic [2:0] BGEZ    = 3'b100;
    localparam logic [2:0] BLEZ    = 3'b101;
    localparam logic [2:0] BGTZ    = 3'b110;

    typedef struct packed {
        logic [EX_DW-1:0] s;
        logic [EX_RW-1:0] rd;
        logic [EX_DW-1:0] pc;
        logic             br_taken;
        logic             exc;
    } entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_e;

endpackage

// File: rtl/ex_br_resolve.sv
// ex_br_resolve: combinational branch-condition decoder.
// Ports:
//   brop  - 3-bit branch op code (ex_pkg BR_* constants)
//   z, n  - zero and negative flags of the compared value
//   taken - branch resolved taken; 0 for no-branch and the reserved code
// Shared with the ID-stage early-branch path.
module ex_br_resolve
    import ex_pkg::*;
(
    input  logic [2:0] brop,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (brop)
            BEQ:     taken = z;
            BNE:     taken = ~z;
            BLTZ:    taken = n;
            BGEZ:    taken = ~n;
            BLEZ:    taken = n | z;
            BGTZ:    taken = ~n & ~z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: EX-stage output register behind the adder/flag unit.
// Captures the sum plus metadata into a two-entry skid buffer, resolves the branch
// condition at capture and raises a signed-overflow exception that blocks issue
// until exc_ack.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - drop all buffered entries (pending trap is kept)
//   in_valid/in_ready   - upstream handshake; in_* carry adder result and metadata
//   out_valid/out_ready - MEM-stage handshake; out_* come from the head register
//   exc_req/exc_epc     - overflow exception request (level) and faulting PC
//   exc_ack             - exception unit acknowledge
// Optional: define EX_STICKY_OVF_EN to add sticky_ovf (out) / sticky_clr (in), a sticky
// record of any signed overflow captured, trapping or not.
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int unsigned DW    = EX_DW,  // must equal EX_DW (entry_t width)
    parameter int unsigned RW    = EX_RW,  // must equal EX_RW (entry_t width)
    parameter int unsigned DEPTH = 2       // only 2 is supported
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_s,
    input  logic          in_z,
    input  logic          in_v,
    input  logic          in_n,
    input  logic          in_sign,
    input  logic          in_trap,
    input  logic [2:0]    in_brop,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_s,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_pc,
    output logic          out_br_taken,
    output logic          out_exc,
    output logic          exc_req,
    output logic [DW-1:0] exc_epc,
    input  logic          exc_ack
`ifdef EX_STICKY_OVF_EN
    ,
    input  logic          sticky_clr,
    output logic          sticky_ovf
`endif
);

    entry_t        head_q, head_d, tail_q, tail_d, new_ent;
    logic [1:0]    count_q, count_d;
    state_e        state_q, state_d;
    logic [DW-1:0] epc_q, epc_d;
    logic          in_ready_q, in_ready_d;
    logic          br_taken, ovf, push, pop;

    ex_br_resolve u_br_resolve (
        .brop  (in_brop),
        .z     (in_z),
        .n     (in_n),
        .taken (br_taken)
    );

    assign ovf  = in_sign & in_v & in_trap;
    // A push coinciding with flush is discarded outright (no capture, no trap).
    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_comb begin
        new_ent          = '0;
        new_ent.s        = in_s;
        new_ent.rd       = ovf ? '0 : in_rd;
        new_ent.pc       = in_pc;
        new_ent.br_taken = br_taken & ~ovf;
        new_ent.exc      = ovf;
    end

    // Skid buffer: head is the older entry, tail only used when two are held.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = new_ent;
                    else                 tail_d = new_ent;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Only reachable with one entry held: new entry replaces the head.
                2'b11:   head_d = new_ent;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        unique case (state_q)
            RUN: begin
                if (push && ovf) begin
                    state_d = TRAP;
                    epc_d   = in_pc;
                end
            end
            TRAP: begin
                if (exc_ack) state_d = RUN;
            end
        endcase
    end

    // Registered from next state so in_ready has no path from out_ready or in_*.
    assign in_ready_d = (state_d == RUN) && (count_d < 2'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            state_q    <= RUN;
            epc_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            epc_q      <= epc_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_s        = head_q.s;
    assign out_rd       = head_q.rd;
    assign out_pc       = head_q.pc;
    assign out_br_taken = head_q.br_taken;
    assign out_exc      = head_q.exc;
    assign exc_req      = (state_q == TRAP);
    assign exc_epc      = epc_q;

`ifdef EX_STICKY_OVF_EN
    logic sticky_q;

    // Set wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (push && in_sign && in_v) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule
